sram_arbiter: RTL and testbench

Two-port arbiter and cycle sequencer for one asynchronous 32-bit SRAM bank (base or ext RAM) of the thinpad SoC. It shares the bank between the CPU instruction-fetch port (read-only) and the data-memory port (read/write with byte enables). It drives the active-low SRAM strobes and the tri-state data bus, and returns data with a one-cycle acknowledge pulse. One instance sits between the CPU core and each SRAM bank in `thinpad_top`.

---
 rtl/sram_arbiter_pkg.sv | 25 ++
 rtl/sram_arb_pick.sv | 46 ++++
 rtl/sram_arbiter.sv | 149 ++++++++++++++
 tb/tb_sram_arbiter.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_arbiter_pkg.sv
// Shared definitions for the SRAM bank arbiter: default bus widths,
// sequencer state encoding and grant encoding.
// Build option: SRAM_ARB_RR_EN selects round-robin arbitration (default is
// fixed priority with the data port winning).
package sram_arbiter_pkg;

  localparam int SRAM_ADDR_W = 20;
  localparam int SRAM_DATA_W = 32;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RD1  = 3'd1,
    S_RD2  = 3'd2,
    S_WR1  = 3'd3,
    S_WR2  = 3'd4,
    S_WR3  = 3'd5,
    S_DONE = 3'd6
  } sram_state_e;

  typedef enum logic {
    GNT_IF  = 1'b0,
    GNT_MEM = 1'b1
  } sram_gnt_e;

endpackage

// File: rtl/sram_arb_pick.sv
// Grant selection between the fetch port and the data port.
// With SRAM_ARB_RR_EN defined the port that was not granted last wins a tie,
// and the preference pointer lives here; otherwise the data port always wins.
module sram_arb_pick
  import sram_arbiter_pkg::*;
(
`ifdef SRAM_ARB_RR_EN
  input  logic      clk,
  input  logic      rst,
  input  logic      grant_en,
`endif
  input  logic      if_req,
  input  logic      mem_req,
  output sram_gnt_e gnt
);

`ifdef SRAM_ARB_RR_EN
  logic prefer_mem_q, prefer_mem_d;

  // Pointer moves away from whichever port was just granted.
  always_comb begin
    prefer_mem_d = prefer_mem_q;
    if (grant_en) prefer_mem_d = (gnt == GNT_IF);
  end

  // Preference register; after reset the data port is preferred.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) prefer_mem_q <= 1'b1;
    else     prefer_mem_q <= prefer_mem_d;
  end

  // Tie broken by the pointer, otherwise the lone requester wins.
  always_comb begin
    gnt = GNT_MEM;
    if (if_req && mem_req) gnt = prefer_mem_q ? GNT_MEM : GNT_IF;
    else if (if_req)       gnt = GNT_IF;
  end
`else
  // Fixed priority: data port wins whenever it requests.
  always_comb begin
    gnt = GNT_IF;
    if (mem_req) gnt = GNT_MEM;
  end
`endif

endmodule

// File: rtl/sram_arbiter.sv
// Two-port arbiter and cycle sequencer for one asynchronous 32-bit SRAM bank.
// Fetch port is read-only; data port reads or writes with byte enables.
// Build option: SRAM_ARB_RR_EN enables round-robin arbitration in sram_arb_pick.
// Handshake: a requester raises req with addr/data stable and holds it until
// its one-cycle ack; the request is latched on the IDLE grant edge, so later
// changes are ignored, and req is only sampled again in the IDLE cycle after ack.
module sram_arbiter
  import sram_arbiter_pkg::*;
#(
  parameter int ADDR_W = SRAM_ADDR_W,
  parameter int DATA_W = SRAM_DATA_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  output logic [DATA_W-1:0]   if_rdata,
  output logic                if_ack,
  input  logic                mem_req,
  input  logic                mem_we,
  input  logic [ADDR_W-1:0]   mem_addr,
  input  logic [DATA_W/8-1:0] mem_be,
  input  logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W-1:0]   mem_rdata,
  output logic                mem_ack,
  inout  wire  [DATA_W-1:0]   ram_data,
  output logic [ADDR_W-1:0]   ram_addr,
  output logic [DATA_W/8-1:0] ram_be_n,
  output logic                ram_ce_n,
  output logic                ram_we_n,
  output sram_state_e         dbg_state
);

  localparam int BE_W = DATA_W / 8;

  sram_state_e       state_q, state_d;
  sram_gnt_e         gnt_q, gnt_d, pick_gnt;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [BE_W-1:0]   be_n_q, be_n_d;
  logic              ce_n_q, ce_n_d, we_n_q, we_n_d, drive_q, drive_d;
  logic              if_ack_q, if_ack_d, mem_ack_q, mem_ack_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d, mem_rdata_q, mem_rdata_d;
  logic              grant_en;

  assign grant_en = (state_q == S_IDLE) && (if_req || mem_req);

  sram_arb_pick u_pick (
`ifdef SRAM_ARB_RR_EN
    .clk      (clk),
    .rst      (rst),
    .grant_en (grant_en),
`endif
    .if_req   (if_req),
    .mem_req  (mem_req),
    .gnt      (pick_gnt)
  );

  // Sequencer next state; the granted request is latched on the IDLE edge.
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    be_n_d  = be_n_q;
    unique case (state_q)
      S_IDLE: begin
        if (grant_en) begin
          gnt_d = pick_gnt;
          if (pick_gnt == GNT_MEM) begin
            addr_d  = mem_addr;
            wdata_d = mem_wdata;
            be_n_d  = mem_we ? ~mem_be : '0;
            state_d = mem_we ? S_WR1 : S_RD1;
          end else begin
            addr_d  = if_addr;
            be_n_d  = '0;
            state_d = S_RD1;
          end
        end
      end
      S_RD1:   state_d = S_RD2;
      S_RD2:   state_d = S_DONE;
      S_WR1:   state_d = S_WR2;
      S_WR2:   state_d = S_WR3;
      S_WR3:   state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Pin and ack values for the coming cycle, so every output leaves a flop.
  always_comb begin
    ce_n_d      = !(state_d inside {S_RD1, S_RD2, S_WR1, S_WR2, S_WR3});
    we_n_d      = (state_d != S_WR2);
    drive_d     = state_d inside {S_WR1, S_WR2, S_WR3};
    if_ack_d    = (state_d == S_DONE) && (gnt_d == GNT_IF);
    mem_ack_d   = (state_d == S_DONE) && (gnt_d == GNT_MEM);
    if_rdata_d  = if_rdata_q;
    mem_rdata_d = mem_rdata_q;
    if (state_q == S_RD2) begin
      if (gnt_q == GNT_IF) if_rdata_d  = ram_data;
      else                 mem_rdata_d = ram_data;
    end
  end

  // State, latched request and registered SRAM pins; reset aborts any access.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      gnt_q       <= GNT_MEM;
      addr_q      <= '0;
      wdata_q     <= '0;
      be_n_q      <= '1;
      ce_n_q      <= 1'b1;
      we_n_q      <= 1'b1;
      drive_q     <= 1'b0;
      if_ack_q    <= 1'b0;
      mem_ack_q   <= 1'b0;
      if_rdata_q  <= '0;
      mem_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      be_n_q      <= be_n_d;
      ce_n_q      <= ce_n_d;
      we_n_q      <= we_n_d;
      drive_q     <= drive_d;
      if_ack_q    <= if_ack_d;
      mem_ack_q   <= mem_ack_d;
      if_rdata_q  <= if_rdata_d;
      mem_rdata_q <= mem_rdata_d;
    end
  end

  assign ram_data  = drive_q ? wdata_q : {DATA_W{1'bz}};
  assign ram_addr  = addr_q;
  assign ram_be_n  = be_n_q;
  assign ram_ce_n  = ce_n_q;
  assign ram_we_n  = we_n_q;
  assign if_ack    = if_ack_q;
  assign mem_ack   = mem_ack_q;
  assign if_rdata  = if_rdata_q;
  assign mem_rdata = mem_rdata_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_sram_arbiter.sv
// Bench for sram_arbiter: a pin-level SRAM model on the bus, a reference
// memory kept by the bench, and one task per scenario.
`timescale 1ns/1ps
module tb_sram_arbiter;
  import sram_arbiter_pkg::*;

  localparam int AW = 20;
  localparam int DW = 32;
  localparam int BW = 4;

  // ---------------- clock / reset / DUT ----------------
  logic clk = 1'b0;
  logic rst;
  logic if_req, mem_req, mem_we;
  logic [AW-1:0] if_addr, mem_addr;
  logic [BW-1:0] mem_be;
  logic [DW-1:0] mem_wdata;
  wire  [DW-1:0] if_rdata, mem_rdata, ram_data;
  wire           if_ack, mem_ack, ram_ce_n, ram_we_n;
  wire  [AW-1:0] ram_addr;
  wire  [BW-1:0] ram_be_n;
  sram_state_e   dbg_state;

  always #5 clk = ~clk;

  sram_arbiter dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .ram_data(ram_data), .ram_addr(ram_addr), .ram_be_n(ram_be_n),
    .ram_ce_n(ram_ce_n), .ram_we_n(ram_we_n), .dbg_state(dbg_state)
  );

  // ---------------- SRAM pin model ----------------
  logic [DW-1:0] sram_mem [256];
  logic          tb_active_write;
  logic          pl_en;
  logic [7:0]    pl_addr;
  logic [DW-1:0] pl_data;
  logic          sram_drive;
  logic [DW-1:0] sram_rd;

  function automatic logic [DW-1:0] init_word(input int i);
    return (32'(i) * 32'h0101_0101) ^ 32'hC3A5_0F00;
  endfunction

  // No output-enable pin exists, so the model drives only outside writes.
  assign sram_drive = !ram_ce_n && ram_we_n && !tb_active_write;
  assign sram_rd    = sram_mem[ram_addr[7:0]];
  assign ram_data   = sram_drive ? sram_rd : {DW{1'bz}};

  initial begin
    for (int i = 0; i < 256; i++) sram_mem[i] = init_word(i);
    forever begin
      @(posedge clk);
      if (pl_en) sram_mem[pl_addr] = pl_data;
      else if (!ram_ce_n && !ram_we_n)
        for (int b = 0; b < BW; b++)
          if (!ram_be_n[b]) sram_mem[ram_addr[7:0]][8*b +: 8] = ram_data[8*b +: 8];
    end
  end

  // ---------------- reference model / scoreboard state ----------------
  logic [DW-1:0] ref_mem [256];
  logic [DW-1:0] exp_if_rd, exp_mem_rd;
  bit            last_gnt_mem;
  int            n_cmp, n_fail;

  function automatic logic [DW-1:0] merge(input logic [DW-1:0] old_w, input logic [DW-1:0] new_w,
                                          input logic [BW-1:0] be);
    logic [DW-1:0] r;
    r = old_w;
    for (int b = 0; b < BW; b++) if (be[b]) r[8*b +: 8] = new_w[8*b +: 8];
    return r;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic preload(input logic [7:0] a, input logic [DW-1:0] d);
    pl_addr = a; pl_data = d; pl_en = 1'b1; ref_mem[a] = d;
    @(posedge clk);
    @(negedge clk);
    pl_en = 1'b0;
  endtask

  // Issues one request at a negedge, holds it until ack, then drops it and
  // steps into the following IDLE cycle so calls chain back to back.
  task automatic run_txn(input bit is_mem, input bit we, input logic [AW-1:0] a,
                         input logic [BW-1:0] be, input logic [DW-1:0] wd,
                         output int lat, output int ce_lo, output int we_lo, output int we_cyc,
                         output logic [DW-1:0] rd, output logic [AW-1:0] saddr,
                         output logic [BW-1:0] sbe_n, output logic [DW-1:0] bus_ack,
                         output logic ack_after);
    lat = 0; ce_lo = 0; we_lo = 0; we_cyc = 0; rd = '0; saddr = '0; sbe_n = '0;
    bus_ack = '0; ack_after = 1'b0;
    if (is_mem) begin
      mem_req = 1'b1; mem_we = we; mem_addr = a; mem_be = be; mem_wdata = wd;
    end else begin
      if_req = 1'b1; if_addr = a;
    end
    tb_active_write = is_mem && we;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (k == 1) begin saddr = ram_addr; sbe_n = ram_be_n; end
      if (!ram_ce_n) ce_lo++;
      if (!ram_we_n) begin we_lo++; we_cyc = k; end
      if (is_mem ? mem_ack : if_ack) begin
        lat = k; rd = is_mem ? mem_rdata : if_rdata; bus_ack = ram_data;
        break;
      end
    end
    if_req = 1'b0; mem_req = 1'b0; tb_active_write = 1'b0;
    @(negedge clk);
    ack_after = if_ack | mem_ack;
  endtask

  // ---------------- scenario tasks ----------------
  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    n_cmp++; if (dbg_state !== S_IDLE) begin n_fail++; $display("FAIL rst_state: got %0d want %0d", dbg_state, S_IDLE); end
    n_cmp++; if (ram_ce_n !== 1'b1) begin n_fail++; $display("FAIL rst_ce_n: got %b want 1", ram_ce_n); end
    n_cmp++; if (ram_we_n !== 1'b1) begin n_fail++; $display("FAIL rst_we_n: got %b want 1", ram_we_n); end
    n_cmp++; if (ram_be_n !== 4'hF) begin n_fail++; $display("FAIL rst_be_n: got %b want 1111", ram_be_n); end
    n_cmp++; if (ram_addr !== 20'h0) begin n_fail++; $display("FAIL rst_addr: got %h want 0", ram_addr); end
    n_cmp++; if ({if_ack, mem_ack} !== 2'b00) begin n_fail++; $display("FAIL rst_acks: got %b want 00", {if_ack, mem_ack}); end
    n_cmp++; if ({if_rdata, mem_rdata} !== 64'h0) begin n_fail++; $display("FAIL rst_rdata: got %h want 0", {if_rdata, mem_rdata}); end
    rst = 1'b0;
    exp_if_rd = '0; exp_mem_rd = '0; last_gnt_mem = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_fetch_read();
    int lat, ce_lo, we_lo, we_cyc; logic [DW-1:0] rd, bus; logic [AW-1:0] sa; logic [BW-1:0] sb; logic aa;
    preload(8'h10, 32'hDEADBEEF);
    run_txn(1'b0, 1'b0, 20'h00010, 4'h0, '0, lat, ce_lo, we_lo, we_cyc, rd, sa, sb, bus, aa);
    exp_if_rd = ref_mem[8'h10]; last_gnt_mem = 1'b0;
    n_cmp++; if (lat !== 3) begin n_fail++; $display("FAIL fetch_latency: got %0d want 3", lat); end
    n_cmp++; if (rd !== exp_if_rd) begin n_fail++; $display("FAIL fetch_data: got %h want %h", rd, exp_if_rd); end
    n_cmp++; if (ce_lo !== 2) begin n_fail++; $display("FAIL fetch_ce_cycles: got %0d want 2", ce_lo); end
    n_cmp++; if (we_lo !== 0) begin n_fail++; $display("FAIL fetch_we_cycles: got %0d want 0", we_lo); end
    n_cmp++; if (sa !== 20'h00010) begin n_fail++; $display("FAIL fetch_addr: got %h want 00010", sa); end
    n_cmp++; if (sb !== 4'b0000) begin n_fail++; $display("FAIL fetch_be_n: got %b want 0000", sb); end
    n_cmp++; if (aa !== 1'b0) begin n_fail++; $display("FAIL fetch_ack_pulse: got %b want 0", aa); end
  endtask

  task automatic test_byte_write();
    int lat, ce_lo, we_lo, we_cyc; logic [DW-1:0] rd, bus; logic [AW-1:0] sa; logic [BW-1:0] sb; logic aa;
    preload(8'h20, 32'hAAAAAAAA);
    run_txn(1'b1, 1'b1, 20'h00020, 4'b0010, 32'h11223344, lat, ce_lo, we_lo, we_cyc, rd, sa, sb, bus, aa);
    ref_mem[8'h20] = merge(ref_mem[8'h20], 32'h11223344, 4'b0010); last_gnt_mem = 1'b1;
    n_cmp++; if (lat !== 4) begin n_fail++; $display("FAIL bwr_latency: got %0d want 4", lat); end
    n_cmp++; if (sram_mem[8'h20] !== 32'hAAAA33AA) begin n_fail++; $display("FAIL bwr_ram_word: got %h want aaaa33aa", sram_mem[8'h20]); end
    n_cmp++; if (we_lo !== 1) begin n_fail++; $display("FAIL bwr_we_cycles: got %0d want 1", we_lo); end
    n_cmp++; if (we_cyc !== 2) begin n_fail++; $display("FAIL bwr_we_position: got %0d want 2", we_cyc); end
    n_cmp++; if (ce_lo !== 3) begin n_fail++; $display("FAIL bwr_ce_cycles: got %0d want 3", ce_lo); end
    n_cmp++; if (sb !== 4'b1101) begin n_fail++; $display("FAIL bwr_be_n: got %b want 1101", sb); end
    n_cmp++; if (bus === 32'h11223344) begin n_fail++; $display("FAIL bwr_bus_release: got %h want released", bus); end
    n_cmp++; if (aa !== 1'b0) begin n_fail++; $display("FAIL bwr_ack_pulse: got %b want 0", aa); end
  endtask

  // Both ports request reads continuously; the expected grant order comes
  // from the arbitration rule applied to the last port served.
  task automatic test_arbitration();
    logic [DW:0] exp_q[$];
    logic [DW:0] got, want;
    bit prev, nxt;
    int n_acks, last_c;
    prev = last_gnt_mem;
    for (int i = 0; i < 8; i++) begin
`ifdef SRAM_ARB_RR_EN
      nxt = !prev;
`else
      nxt = 1'b1;
`endif
      exp_q.push_back({nxt, nxt ? ref_mem[8'h60] : ref_mem[8'h61]});
      if (nxt) exp_mem_rd = ref_mem[8'h60]; else exp_if_rd = ref_mem[8'h61];
      prev = nxt;
    end
    mem_req = 1'b1; mem_we = 1'b0; mem_addr = 20'h00060; if_req = 1'b1; if_addr = 20'h00061;
    n_acks = 0; last_c = 0;
    for (int c = 1; c <= 60 && n_acks < 8; c++) begin
      @(negedge clk);
      if (if_ack || mem_ack) begin
        got  = mem_ack ? {1'b1, mem_rdata} : {1'b0, if_rdata};
        want = exp_q.pop_front();
        n_cmp++; if (got !== want) begin n_fail++; $display("FAIL arb_grant_%0d: got %h want %h", n_acks, got, want); end
        n_cmp++; if (if_ack && mem_ack) begin n_fail++; $display("FAIL arb_dual_ack: got 11 want one-hot"); end
        n_cmp++; if ((c - last_c) !== ((n_acks == 0) ? 3 : 4)) begin
          n_fail++; $display("FAIL arb_spacing_%0d: got %0d want %0d", n_acks, c - last_c, (n_acks == 0) ? 3 : 4);
        end
        last_c = c; n_acks++;
      end
    end
    mem_req = 1'b0; if_req = 1'b0;
    n_cmp++; if (n_acks !== 8) begin n_fail++; $display("FAIL arb_ack_count: got %0d want 8", n_acks); end
    last_gnt_mem = prev;
    @(negedge clk);
  endtask

  task automatic test_write_read();
    int lat, ce_lo, we_lo, we_cyc; logic [DW-1:0] rd, bus; logic [AW-1:0] sa; logic [BW-1:0] sb; logic aa;
    run_txn(1'b1, 1'b1, 20'h00030, 4'hF, 32'h5A5A5A5A, lat, ce_lo, we_lo, we_cyc, rd, sa, sb, bus, aa);
    ref_mem[8'h30] = merge(ref_mem[8'h30], 32'h5A5A5A5A, 4'hF);
    n_cmp++; if (lat !== 4) begin n_fail++; $display("FAIL wr_latency: got %0d want 4", lat); end
    n_cmp++; if (bus === 32'h5A5A5A5A) begin n_fail++; $display("FAIL wr_done_bus: got %h want released", bus); end
    run_txn(1'b1, 1'b0, 20'h00030, 4'h0, '0, lat, ce_lo, we_lo, we_cyc, rd, sa, sb, bus, aa);
    exp_mem_rd = ref_mem[8'h30]; last_gnt_mem = 1'b1;
    n_cmp++; if (lat !== 3) begin n_fail++; $display("FAIL rd_b2b_latency: got %0d want 3", lat); end
    n_cmp++; if (rd !== 32'h5A5A5A5A) begin n_fail++; $display("FAIL rd_b2b_data: got %h want 5a5a5a5a", rd); end
    n_cmp++; if (sb !== 4'b0000) begin n_fail++; $display("FAIL rd_b2b_be_n: got %b want 0000", sb); end
  endtask

  task automatic test_reset_mid_write();
    int lat, ce_lo, we_lo, we_cyc, late_acks; logic [DW-1:0] rd, bus; logic [AW-1:0] sa; logic [BW-1:0] sb; logic aa;
    mem_req = 1'b1; mem_we = 1'b1; mem_addr = 20'h00070; mem_be = 4'hF; mem_wdata = 32'h0BAD_F00D;
    tb_active_write = 1'b1;
    repeat (2) @(negedge clk);
    n_cmp++; if (ram_we_n !== 1'b0) begin n_fail++; $display("FAIL rmw_in_wr2: got %b want 0", ram_we_n); end
    rst = 1'b1; mem_req = 1'b0; tb_active_write = 1'b0;
    @(negedge clk);
    n_cmp++; if ({ram_we_n, ram_ce_n} !== 2'b11) begin n_fail++; $display("FAIL rmw_strobes: got %b want 11", {ram_we_n, ram_ce_n}); end
    n_cmp++; if (ram_be_n !== 4'hF) begin n_fail++; $display("FAIL rmw_be_n: got %b want 1111", ram_be_n); end
    n_cmp++; if (ram_addr !== 20'h0) begin n_fail++; $display("FAIL rmw_addr: got %h want 0", ram_addr); end
    n_cmp++; if (ram_data === 32'h0BADF00D) begin n_fail++; $display("FAIL rmw_bus: got %h want released", ram_data); end
    n_cmp++; if ({if_rdata, mem_rdata} !== 64'h0) begin n_fail++; $display("FAIL rmw_rdata: got %h want 0", {if_rdata, mem_rdata}); end
    rst = 1'b0; exp_if_rd = '0; exp_mem_rd = '0; last_gnt_mem = 1'b0;
    late_acks = 0;
    repeat (5) begin @(negedge clk); if (mem_ack || if_ack) late_acks++; end
    n_cmp++; if (late_acks !== 0) begin n_fail++; $display("FAIL rmw_no_ack: got %0d want 0", late_acks); end
    run_txn(1'b1, 1'b0, 20'h00070, 4'h0, '0, lat, ce_lo, we_lo, we_cyc, rd, sa, sb, bus, aa);
    exp_mem_rd = ref_mem[8'h70]; last_gnt_mem = 1'b1;
    n_cmp++; if (lat !== 3) begin n_fail++; $display("FAIL rmw_read_latency: got %0d want 3", lat); end
    n_cmp++; if (rd !== exp_mem_rd) begin n_fail++; $display("FAIL rmw_read_data: got %h want %h", rd, exp_mem_rd); end
  endtask

  task automatic test_addr_change();
    int lat;
    if_req = 1'b1; if_addr = 20'h00040; lat = 0;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (k == 1) if_addr = 20'h00050;
      if (k == 2) begin
        n_cmp++; if (ram_addr !== 20'h00040) begin n_fail++; $display("FAIL achg_ram_addr: got %h want 00040", ram_addr); end
      end
      if (if_ack) begin
        lat = k;
        n_cmp++; if (if_rdata !== ref_mem[8'h40]) begin n_fail++; $display("FAIL achg_data: got %h want %h", if_rdata, ref_mem[8'h40]); end
        break;
      end
    end
    if_req = 1'b0; exp_if_rd = ref_mem[8'h40]; last_gnt_mem = 1'b0;
    n_cmp++; if (lat !== 3) begin n_fail++; $display("FAIL achg_latency: got %0d want 3", lat); end
    @(negedge clk);
  endtask

  task automatic test_random();
    int lat, ce_lo, we_lo, we_cyc; logic [DW-1:0] rd, bus; logic [AW-1:0] sa; logic [BW-1:0] sb; logic aa;
    bit is_mem, we; logic [AW-1:0] a; logic [BW-1:0] be; logic [DW-1:0] wd;
    for (int t = 0; t < 40; t++) begin
      is_mem = 1'($urandom_range(0, 1));
      we     = is_mem ? 1'($urandom_range(0, 1)) : 1'b0;
      a      = AW'($urandom_range(0, 255));
      be     = BW'($urandom_range(0, 15));
      wd     = $urandom();
      run_txn(is_mem, we, a, be, wd, lat, ce_lo, we_lo, we_cyc, rd, sa, sb, bus, aa);
      last_gnt_mem = is_mem;
      if (we) begin
        ref_mem[a[7:0]] = merge(ref_mem[a[7:0]], wd, be);
        n_cmp++; if (lat !== 4) begin n_fail++; $display("FAIL rnd%0d_wr_latency: got %0d want 4", t, lat); end
        n_cmp++; if (sram_mem[a[7:0]] !== ref_mem[a[7:0]]) begin n_fail++; $display("FAIL rnd%0d_wr_word: got %h want %h", t, sram_mem[a[7:0]], ref_mem[a[7:0]]); end
        n_cmp++; if (we_lo !== 1) begin n_fail++; $display("FAIL rnd%0d_we_cycles: got %0d want 1", t, we_lo); end
      end else begin
        if (is_mem) exp_mem_rd = ref_mem[a[7:0]]; else exp_if_rd = ref_mem[a[7:0]];
        n_cmp++; if (lat !== 3) begin n_fail++; $display("FAIL rnd%0d_rd_latency: got %0d want 3", t, lat); end
        n_cmp++; if (rd !== ref_mem[a[7:0]]) begin n_fail++; $display("FAIL rnd%0d_rd_data: got %h want %h", t, rd, ref_mem[a[7:0]]); end
      end
      n_cmp++; if (sa !== a) begin n_fail++; $display("FAIL rnd%0d_addr: got %h want %h", t, sa, a); end
      n_cmp++; if (sb !== (we ? ~be : 4'b0000)) begin n_fail++; $display("FAIL rnd%0d_be_n: got %b want %b", t, sb, we ? ~be : 4'b0000); end
      n_cmp++; if (if_rdata !== exp_if_rd) begin n_fail++; $display("FAIL rnd%0d_if_hold: got %h want %h", t, if_rdata, exp_if_rd); end
      n_cmp++; if (mem_rdata !== exp_mem_rd) begin n_fail++; $display("FAIL rnd%0d_mem_hold: got %h want %h", t, mem_rdata, exp_mem_rd); end
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    n_cmp = 0; n_fail = 0;
    rst = 1'b1; if_req = 1'b0; mem_req = 1'b0; mem_we = 1'b0;
    if_addr = '0; mem_addr = '0; mem_be = '0; mem_wdata = '0;
    tb_active_write = 1'b0; pl_en = 1'b0; pl_addr = '0; pl_data = '0;
    exp_if_rd = '0; exp_mem_rd = '0; last_gnt_mem = 1'b0;
    for (int i = 0; i < 256; i++) ref_mem[i] = init_word(i);
    test_reset();
    test_fetch_read();
    test_byte_write();
    test_arbitration();
    test_write_read();
    test_reset_mid_write();
    test_addr_change();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
